chaotic_bit_extractor: RTL and testbench
========================================

Name: chaotic_bit_extractor

Overview:
- Downstream consumer of the chaotic-equation top stage. It sits after the block that takes calcu_ctrl/busy and returns n1_valid/xn1/yn1/zn1.
- Paces iterations by generating calcu_ctrl rising edges and waiting for each result.
- Discards the first DISCARD_ITERS results as the transient.
- Folds the low mantissa bits of x/y/z into one word, buffers words in a FIFO, and serialises them LSB-first as a valid/ready bit stream (M-sequence/key source).

Parameters:
- DATA_WIDTH, 64: width of xn1/yn1/zn1. Matches the floating-point IP width.
- BITS_PER_SAMPLE, 16: low bits taken per axis. Legal range 1..52.
- DISCARD_ITERS, 8: leading iteration results dropped after reset. 0 means none dropped.
- FIFO_DEPTH, 4: word FIFO depth. Must be a power of 2, at least 2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous reset, active-low
- enable  in  1  permits new iteration requests
- busy  in  1  upstream busy
- n1_valid  in  1  upstream result strobe
- xn1  in  DATA_WIDTH  upstream x result
- yn1  in  DATA_WIDTH  upstream y result
- zn1  in  DATA_WIDTH  upstream z result
- calcu_ctrl  out  1  registered request level; its rising edge triggers one iteration
- bit_out  out  1  serial data, LSB of word first
- bit_valid  out  1  bit_out is valid
- bit_ready  in  1  sink accepts bit_out
- fifo_level  out  $clog2(FIFO_DEPTH+1)  words in FIFO, excluding the serializer
- discard_done  out  1  high once DISCARD_ITERS results have been dropped
- spurious_valid  out  1  sticky flag: n1_valid seen outside WAIT_V

Behaviour:
- One clock. Reset is asynchronous and active-low on rst_n. All state is cleared on rst_n low.
- Reset values:
  - calcu_ctrl, bit_out, bit_valid, spurious_valid: 0.
  - fifo_level: 0.
  - discard_done: 1 if DISCARD_ITERS == 0, else 0.
  - FSM in IDLE, discard counter 0, serializer empty.
- Request FSM, states IDLE, REQ, WAIT_V:
  - IDLE:
    - If enable=1, busy=0 and fifo_level < FIFO_DEPTH: go to REQ and drive calcu_ctrl=1 next cycle.
    - Otherwise stay, with calcu_ctrl=0.
  - REQ: calcu_ctrl is high for exactly one cycle, then drops to 0.
    - If busy=1 is sampled in this cycle, upstream rejected the edge: return to IDLE. The IDLE cycle guarantees at least one low cycle before the retry.
    - Else go to WAIT_V.
  - WAIT_V: wait indefinitely for n1_valid, then return to IDLE.
    - On n1_valid with discard counter < DISCARD_ITERS: increment the counter and push nothing. discard_done rises when the counter reaches DISCARD_ITERS.
    - On n1_valid otherwise: push the word into the FIFO on that edge.
    - enable falling during WAIT_V does not abort; the in-flight result is still processed.
- Only one iteration is in flight at a time. The fifo_level < FIFO_DEPTH check at request time guarantees the FIFO never overflows. No write is dropped.
- Word formation: W = xn1[K-1:0] XOR yn1[K-1:0] XOR zn1[K-1:0], where K = BITS_PER_SAMPLE. Raw bits only; no float arithmetic.
- Serializer (shift register plus bit counter):
  - When empty and the FIFO is non-empty, pop into the shift register on the next edge. bit_valid=1 and bit_out=sreg[0].
  - On bit_valid & bit_ready: shift right and decrement the count.
  - After the last bit is accepted: if the FIFO is non-empty, reload in the same edge (no bubble); else bit_valid=0.
  - bit_valid and bit_out are stable while bit_ready=0.
- Simultaneous FIFO push and pop in one edge is legal; fifo_level is unchanged.
- Latency: with the FIFO and serializer empty, n1_valid sampled at edge E0 gives bit_valid=1 after edge E0+2.
- An n1_valid arriving in IDLE or REQ sets spurious_valid (sticky until reset). It causes no push and no state change.
- Reset mid-operation: everything clears and the discard count restarts. Upstream is reset on the same rst_n.

Decomposition:
- Shared package chaotic_pkg:
  - FSM state enum {IDLE, REQ, WAIT_V}.
  - Localparams for counter widths: $clog2(BITS_PER_SAMPLE+1), $clog2(DISCARD_ITERS+1), $clog2(FIFO_DEPTH+1).
- One sub-module, chaotic_word_fifo: synchronous FIFO with count output; first-word-fall-through is not required.
- FSM, word XOR and serializer stay in the top module.

Test Plan (DATA_WIDTH=64, BITS_PER_SAMPLE=16, DISCARD_ITERS=2, FIFO_DEPTH=4; behavioural upstream model, latency 20, busy high from edge to result):
- Reset: assert rst_n=0 mid-run -> calcu_ctrl=0, bit_valid=0, fifo_level=0, discard_done=0, spurious_valid=0 immediately (asynchronous).
- Discard and word: enable=1, bit_ready=1; model returns two arbitrary results, then x=0x...00F0, y=0x...000F, z=0x...0000.
  - No bits from the first two results; discard_done=1 after the 2nd.
  - Then 16 bits: 1,1,1,1,1,1,1,1,0,0,0,0,0,0,0,0.
  - bit_valid rises 2 edges after the 3rd n1_valid.
- Backpressure: bit_ready=0, enable=1 -> exactly 5 post-discard words are accepted (1 in serializer, 4 in FIFO).
  - fifo_level=4; calcu_ctrl stays 0 thereafter.
  - Release bit_ready -> 80 bits in generation order, no bubble between words; requests resume.
- Rejected request: force busy=1 during the REQ cycle -> FSM returns to IDLE; calcu_ctrl low at least 1 cycle; re-requests once busy=0; no hang in WAIT_V.
- Spurious strobe: pulse n1_valid while in IDLE -> spurious_valid=1 (sticky); fifo_level and discard counter unchanged.
- Enable drop: deassert enable during WAIT_V -> that result is still pushed; no further calcu_ctrl edges; serializer drains to bit_valid=0.

Source files
------------

// File: rtl/chaotic_pkg.sv
// Shared types and width helpers for the chaotic bit extractor slice.
package chaotic_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_V
  } req_state_t;

  // Width of a counter that must hold 0..max_val inclusive, never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  localparam int DEF_BIT_CNT_W  = cnt_width(16);
  localparam int DEF_DISC_CNT_W = cnt_width(8);
  localparam int DEF_LEVEL_W    = $clog2(4 + 1);

endpackage

// File: rtl/chaotic_word_fifo.sv
// Synchronous word FIFO with occupancy count; a written word becomes readable one cycle
// after its push, as it would with a registered-memory FIFO.
module chaotic_word_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_q;
  logic             do_push;
  logic             do_pop;

  // The word pushed on the last edge is counted but not yet visible to the reader.
  assign empty   = (count == {{(CW-1){1'b0}}, push_q});
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      push_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count  <= count + CW'(do_push) - CW'(do_pop);
      push_q <= do_push;
    end
  end

endmodule

// File: rtl/chaotic_bit_extractor.sv
// Paces chaotic-equation iterations, drops the transient, folds x/y/z low bits into words
// and streams them LSB-first over a valid/ready bit interface.
module chaotic_bit_extractor
  import chaotic_pkg::*;
#(
  parameter int DATA_WIDTH      = 64,
  parameter int BITS_PER_SAMPLE = 16,
  parameter int DISCARD_ITERS   = 8,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            enable,
  input  logic                            busy,
  input  logic                            n1_valid,
  input  logic [DATA_WIDTH-1:0]           xn1,
  input  logic [DATA_WIDTH-1:0]           yn1,
  input  logic [DATA_WIDTH-1:0]           zn1,
  output logic                            calcu_ctrl,
  output logic                            bit_out,
  output logic                            bit_valid,
  input  logic                            bit_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
  output logic                            discard_done,
  output logic                            spurious_valid
);

  localparam int K      = BITS_PER_SAMPLE;
  localparam int BIT_W  = cnt_width(K);
  localparam int DISC_W = cnt_width(DISCARD_ITERS);
  localparam logic [DISC_W-1:0] DISC_MAX = DISC_W'(DISCARD_ITERS);
  localparam logic [BIT_W-1:0]  BITS_MAX = BIT_W'(K);
  localparam logic [BIT_W-1:0]  BIT_ONE  = BIT_W'(1);

  req_state_t        state;
  req_state_t        next_state;
  logic [DISC_W-1:0] disc_cnt;
  logic [K-1:0]      word;
  logic [K-1:0]      fifo_rdata;
  logic              fifo_empty;
  logic              fifo_full;
  logic              result_fire;
  logic              push;
  logic [K-1:0]      sreg;
  logic [BIT_W-1:0]  bit_cnt;
  logic              last_accept;
  logic              load;
  logic              unused_hi;

  assign word      = xn1[K-1:0] ^ yn1[K-1:0] ^ zn1[K-1:0];
  assign unused_hi = ^{xn1[DATA_WIDTH-1:K], yn1[DATA_WIDTH-1:K], zn1[DATA_WIDTH-1:K]};

  assign discard_done = (disc_cnt == DISC_MAX);
  assign result_fire  = (state == WAIT_V) && n1_valid;
  assign push         = result_fire && discard_done;

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (enable && !busy && !fifo_full) next_state = REQ;
      REQ:     next_state = busy ? IDLE : WAIT_V;
      WAIT_V:  if (n1_valid) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // calcu_ctrl is registered so upstream sees a clean one-cycle level per request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      calcu_ctrl <= 1'b0;
    end else begin
      state      <= next_state;
      calcu_ctrl <= (next_state == REQ);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disc_cnt       <= '0;
      spurious_valid <= 1'b0;
    end else begin
      if (result_fire && !discard_done) begin
        disc_cnt <= disc_cnt + 1'b1;
      end
      if (n1_valid && (state != WAIT_V)) begin
        spurious_valid <= 1'b1;
      end
    end
  end

  chaotic_word_fifo #(
    .WIDTH(K),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (word),
    .pop   (load),
    .rdata (fifo_rdata),
    .count (fifo_level),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // Reloading on the final accepted bit keeps back-to-back words free of bubbles.
  assign last_accept = bit_valid && bit_ready && (bit_cnt == BIT_ONE);
  assign load        = (!bit_valid || last_accept) && !fifo_empty;
  assign bit_out     = sreg[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg      <= '0;
      bit_cnt   <= '0;
      bit_valid <= 1'b0;
    end else if (load) begin
      sreg      <= fifo_rdata;
      bit_cnt   <= BITS_MAX;
      bit_valid <= 1'b1;
    end else if (bit_valid && bit_ready) begin
      sreg    <= sreg >> 1;
      bit_cnt <= bit_cnt - BIT_ONE;
      if (last_accept) begin
        bit_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_chaotic_bit_extractor.sv
// Directed/random bench for chaotic_bit_extractor with a behavioural upstream and bit scoreboard.
module tb_chaotic_bit_extractor;

  localparam int DW  = 64;
  localparam int K   = 16;
  localparam int D   = 2;
  localparam int F   = 4;
  localparam int LAT = 20;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          busy;
  logic          n1_valid;
  logic [DW-1:0] xn1;
  logic [DW-1:0] yn1;
  logic [DW-1:0] zn1;
  logic          calcu_ctrl;
  logic          bit_out;
  logic          bit_valid;
  logic          bit_ready;
  logic [2:0]    fifo_level;
  logic          discard_done;
  logic          spurious_valid;

  logic m_busy, m_valid, force_busy, spur, model_off;
  bit   m_active, ctrl_prev, ctrl_seen;
  int   m_cnt, res_total, res_idx, words_total;
  int   checks, failures;
  bit            exp_bits[$];
  logic [DW-1:0] dir_q[$];

  assign busy     = m_busy | force_busy;
  assign n1_valid = m_valid | spur;

  always #5 clk = ~clk;

  chaotic_bit_extractor #(
    .DATA_WIDTH(DW),
    .BITS_PER_SAMPLE(K),
    .DISCARD_ITERS(D),
    .FIFO_DEPTH(F)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .busy(busy), .n1_valid(n1_valid),
    .xn1(xn1), .yn1(yn1), .zn1(zn1), .calcu_ctrl(calcu_ctrl), .bit_out(bit_out),
    .bit_valid(bit_valid), .bit_ready(bit_ready), .fifo_level(fifo_level),
    .discard_done(discard_done), .spurious_valid(spurious_valid)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic en, input logic rdy);
    enable    = en;
    bit_ready = rdy;
  endtask

  task automatic waitResults(input int target, input int budget, input string tag);
    int n = 0;
    while (res_total < target && n < budget) begin
      tick();
      n++;
    end
    checkOutput(tag, 64'(res_total >= target), 64'd1);
  endtask

  task automatic waitDrain(input string tag);
    int n = 0;
    repeat (2) tick();
    while ((m_active || exp_bits.size() != 0 || bit_valid !== 1'b0) && n < 600) begin
      tick();
      n++;
    end
    checkOutput({tag, "_drained"}, 64'(n < 600), 64'd1);
    checkOutput({tag, "_level"}, 64'(fifo_level), 64'd0);
  endtask

  // Upstream: busy from the cycle after a calcu_ctrl rise until the result strobe LAT cycles later.
  initial begin
    logic [DW-1:0] w;
    m_busy = 0; m_valid = 0; xn1 = '0; yn1 = '0; zn1 = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_busy = 0; m_valid = 0; m_active = 0; ctrl_prev = 0; res_idx = 0;
        exp_bits.delete();
      end else begin
        m_valid = 0;
        if (m_active) begin
          m_cnt++;
          if (m_cnt == 1) m_busy = 1;
          if (m_cnt == LAT) begin
            if (dir_q.size() >= 3) begin
              xn1 = dir_q.pop_front(); yn1 = dir_q.pop_front(); zn1 = dir_q.pop_front();
            end else begin
              xn1 = {$urandom, $urandom}; yn1 = {$urandom, $urandom}; zn1 = {$urandom, $urandom};
            end
            m_valid = 1; m_busy = 0; m_active = 0;
            res_total++;
            if (res_idx >= D) begin
              w = (xn1 ^ yn1 ^ zn1) % (64'd1 << K);
              for (int b = 0; b < K; b++) exp_bits.push_back(bit'((w >> b) & 64'd1));
              words_total++;
            end
            res_idx++;
          end
        end else if (calcu_ctrl && !ctrl_prev && !model_off) begin
          m_active = 1;
          m_cnt    = 0;
        end
        ctrl_prev = calcu_ctrl;
      end
    end
  end

  // Bit scoreboard: every accepted bit must be the next expected one.
  initial begin
    bit e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n === 1'b1 && bit_valid === 1'b1 && bit_ready === 1'b1) begin
        checkOutput("bit_expected", 64'(exp_bits.size() != 0), 64'd1);
        if (exp_bits.size() != 0) begin
          e = exp_bits.pop_front();
          checkOutput("bit_out", 64'(bit_out), 64'(e));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int r0, w0, n;
    checks = 0; failures = 0; res_total = 0; words_total = 0;
    rst_n = 0; force_busy = 0; spur = 0; model_off = 0;
    applyStimulus(0, 0);
    repeat (3) tick();
    checkOutput("rst_calcu_ctrl", 64'(calcu_ctrl), 64'd0);
    checkOutput("rst_bit_valid", 64'(bit_valid), 64'd0);
    checkOutput("rst_fifo_level", 64'(fifo_level), 64'd0);
    checkOutput("rst_discard_done", 64'(discard_done), 64'd0);
    checkOutput("rst_spurious", 64'(spurious_valid), 64'd0);
    rst_n = 1;
    tick();

    // Spurious strobe while idle: sticky flag, no push, discard count untouched.
    spur = 1; tick(); spur = 0; tick();
    checkOutput("spur_flag", 64'(spurious_valid), 64'd1);
    checkOutput("spur_level", 64'(fifo_level), 64'd0);
    checkOutput("spur_discard_done", 64'(discard_done), 64'd0);
    checkOutput("spur_bit_valid", 64'(bit_valid), 64'd0);

    // Two arbitrary transient results, then the directed word 0x00FF.
    repeat (6) dir_q.push_back({$urandom, $urandom});
    dir_q.push_back(64'h0000_0000_0000_00F0);
    dir_q.push_back(64'h0000_0000_0000_000F);
    dir_q.push_back(64'h0000_0000_0000_0000);
    applyStimulus(1, 1);
    waitResults(1, 100, "first_result");
    tick();
    checkOutput("disc1_done", 64'(discard_done), 64'd0);
    checkOutput("disc1_bit_valid", 64'(bit_valid), 64'd0);
    waitResults(2, 100, "second_result");
    tick();
    checkOutput("disc2_done", 64'(discard_done), 64'd1);
    checkOutput("disc2_bit_valid", 64'(bit_valid), 64'd0);
    waitResults(3, 100, "third_result");
    tick();
    checkOutput("lat_e0p1", 64'(bit_valid), 64'd0);
    tick();
    checkOutput("lat_e0p2", 64'(bit_valid), 64'd0);
    tick();
    checkOutput("lat_after_e0p2", 64'(bit_valid), 64'd1);
    waitResults(5, 200, "run_results");
    applyStimulus(0, 1);
    waitDrain("drain1");

    // Backpressure: one word in the serializer plus a full FIFO, then no more requests.
    w0 = words_total;
    applyStimulus(1, 0);
    repeat (300) tick();
    checkOutput("bp_words", 64'(words_total - w0), 64'd5);
    checkOutput("bp_level", 64'(fifo_level), 64'd4);
    checkOutput("bp_bit_valid", 64'(bit_valid), 64'd1);
    ctrl_seen = 0;
    repeat (30) begin
      if (calcu_ctrl) ctrl_seen = 1;
      tick();
    end
    checkOutput("bp_no_request", 64'(ctrl_seen), 64'd0);
    applyStimulus(1, 1);
    ctrl_seen = 0;
    for (int i = 0; i < 80; i++) begin
      checkOutput("bp_no_bubble", 64'(bit_valid), 64'd1);
      if (calcu_ctrl) ctrl_seen = 1;
      tick();
    end
    checkOutput("bp_requests_resume", 64'(ctrl_seen), 64'd1);
    applyStimulus(0, 1);
    waitDrain("drain2");

    // Rejected request: busy during the REQ cycle sends the FSM back to IDLE.
    model_off = 1;
    applyStimulus(1, 1);
    n = 0;
    while (calcu_ctrl !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checkOutput("rej_req_seen", 64'(calcu_ctrl), 64'd1);
    force_busy = 1;
    tick();
    checkOutput("rej_ctrl_drop", 64'(calcu_ctrl), 64'd0);
    repeat (3) begin
      tick();
      checkOutput("rej_ctrl_low", 64'(calcu_ctrl), 64'd0);
    end
    r0 = res_total;
    force_busy = 0;
    model_off  = 0;
    waitResults(r0 + 1, 100, "rej_retry_result");
    applyStimulus(0, 1);
    waitDrain("drain3");

    // Enable drop mid-iteration: the in-flight result is still delivered.
    r0 = res_total;
    applyStimulus(1, 1);
    n = 0;
    while (m_busy !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checkOutput("drop_in_flight", 64'(m_busy), 64'd1);
    applyStimulus(0, 1);
    waitResults(r0 + 1, 100, "drop_result");
    ctrl_seen = 0;
    repeat (60) begin
      if (calcu_ctrl) ctrl_seen = 1;
      tick();
    end
    checkOutput("drop_no_request", 64'(ctrl_seen), 64'd0);
    checkOutput("drop_bit_valid", 64'(bit_valid), 64'd0);
    checkOutput("drop_bits_left", 64'(exp_bits.size()), 64'd0);
    checkOutput("spur_sticky", 64'(spurious_valid), 64'd1);

    // Asynchronous reset mid-run, then the discard sequence restarts.
    applyStimulus(1, 0);
    repeat (80) tick();
    rst_n = 0;
    #1;
    checkOutput("arst_calcu_ctrl", 64'(calcu_ctrl), 64'd0);
    checkOutput("arst_bit_valid", 64'(bit_valid), 64'd0);
    checkOutput("arst_fifo_level", 64'(fifo_level), 64'd0);
    checkOutput("arst_discard_done", 64'(discard_done), 64'd0);
    checkOutput("arst_spurious", 64'(spurious_valid), 64'd0);
    repeat (3) tick();
    rst_n = 1;
    tick();
    r0 = res_total;
    applyStimulus(1, 1);
    waitResults(r0 + 2, 100, "post_rst_discards");
    tick();
    checkOutput("post_rst_done", 64'(discard_done), 64'd1);
    checkOutput("post_rst_bit_valid", 64'(bit_valid), 64'd0);
    waitResults(r0 + 4, 100, "post_rst_words");
    applyStimulus(0, 1);
    waitDrain("drain4");
    checkOutput("final_bits_left", 64'(exp_bits.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
